alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked ALU for the NPC datapath experiments. It generalises the switch-driven 4-bit ALU to `WIDTH` bits. Operands and results are registered, and valid/ready handshakes sit on both sides. An optional multi-cycle shift-add multiplier is included. The block sits between an operand source (switch sampler or decode stage) and a result consumer (LED driver or writeback).

## Interface
- `WIDTH`, default 4: operand and result width. Must be at least 2.
- `clk` input 1: the single clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: the operand bundle is valid.
- `in_ready` output 1: the block can accept a bundle this cycle.
- `op` input 4: operation select.
  - `0000` add, `0001` sub, `0010` not a, `0011` and, `0100` or, `0101` xor.
  - `0110` signed less-than, `0111` equal, `1000` mul.
  - `1001`–`1111` reserved.
- `a`, `b` input `WIDTH`: operands, two's complement where signed.
- `out_valid` output 1: the result bundle is valid.
- `out_ready` input 1: the consumer takes the result this cycle.
- `result` output `WIDTH`: operation result.
- `zero` output 1: high when `result` is all zeros.
- `cout` output 1: carry out (add/sub) or unsigned overflow (mul).
- `overflow` output 1: signed overflow (add/sub).
- `err` output 1: the op was reserved or disabled.

## Operation
- **Handshakes**
  - Input transfer occurs when `in_valid & in_ready`. `op`, `a` and `b` are captured on that edge.
  - Output transfer occurs when `out_valid & out_ready`.
- **FSM states**
  - IDLE: `in_ready=1`. On accept, a single-cycle op goes to DONE and mul goes to BUSY.
  - BUSY: multiplier iterating, `in_ready=0`. When the counter reaches `WIDTH-1`, go to DONE.
  - DONE: `out_valid=1`, `in_ready=out_ready`.
    - Output transfer with no new accept: go to IDLE.
    - Output transfer with a new accept: go to DONE or BUSY according to the new op.
    - No `out_ready`: hold.
- **Arithmetic**
  - Add: `{cout,result} = a+b`. `overflow` = operands have equal sign and `result` sign differs.
  - Sub: computed as `a + ~b + 1`. `cout=1` means no borrow. `overflow` = operand signs differ and `result` sign differs from `a`.
  - Less-than: internal subtract, then `result = {0…, diff[W-1]^ovf}`. `cout=0`, `overflow=0`.
  - Equal: `result = {0…, a==b}`. `cout=0`, `overflow=0`.
  - Logic ops: `cout=0`, `overflow=0`.
- **Multiply (unsigned shift-add)**
  - `WIDTH` iterations, one multiplier bit per cycle, 2·`WIDTH`-bit accumulator.
  - `result` is the low `WIDTH` bits.
  - `cout` = OR of the high `WIDTH` bits.
  - `overflow=0`.
- **Reserved op**
  - Goes to DONE after 1 cycle with `result=0`, `zero=1`, `err=1`, `cout=0`, `overflow=0`.
  - For every valid op, `err=0`.
- **Output stability:** `result` and all flags are registered. They stay constant while `out_valid & !out_ready`.
- **Input while busy:** input presented during BUSY, or during DONE without `out_ready`, is not accepted. The producer must hold it.
- **Reset mid-operation:** any state returns to IDLE immediately and the in-flight op is discarded. No output transfer occurs.

## Timing
- **Reset values:** `out_valid=0`, `result=0`, `zero=0`, `cout=0`, `overflow=0`, `err=0`, `in_ready=1`. State is IDLE and the multiply counter is 0.
- **Latency, single-cycle ops and reserved ops:** `out_valid` rises on the edge that accepts the op, so the result is visible the cycle after acceptance.
- **Latency, mul:** `out_valid` rises `WIDTH+1` cycles after acceptance.
- **Throughput:** one single-cycle op per clock when `out_ready` is held high. A mul blocks input for `WIDTH+1` cycles.
- **Path depth:** `in_ready` is combinational from state and `out_ready` only. There is no combinational path from `in_valid` to `out_valid`.

## Configuration
- **`ALU_MUL_EN` defined:** multiplier datapath, the BUSY state and the iteration counter are compiled in. Op `1000` behaves as specified above.
- **`ALU_MUL_EN` undefined:**
  - No multiplier logic, and BUSY is unreachable.
  - Op `1000` is treated as reserved: 1-cycle latency, `result=0`, `err=1`.

## Test plan
- **Add, `WIDTH=4`:** 7+9 -> `result=0000`, `zero=1`, `cout=1`, `overflow=0`, `out_valid` 1 cycle after accept.
- **Sub and less-than, `WIDTH=4`:**
  - Sub 3−5 -> `1110`, `cout=0`, `overflow=0`.
  - Less-than a=`1000`, b=`0111` -> `result=0001`.
  - Equal 5,5 -> `result=0001`.
- **Backpressure:**
  - Hold `out_ready=0` for 3 cycles after xor `1100`^`1010` -> `result=0110` stable and `in_ready=0` throughout.
  - Then with `out_ready=1` and a new `in_valid` -> new op accepted on the same edge.
- **Multiply, `ALU_MUL_EN`, `WIDTH=4`:** 7×6 -> `result=1010`, `cout=1`, `out_valid` 5 cycles after accept, `in_ready=0` during BUSY.
- **Reset mid-multiply:** assert `rst=0` in the 2nd BUSY cycle -> `out_valid=0`, `in_ready=1`, all outputs 0. After release, add 1+1 -> `0010`.
- **Reserved op:** op `1111` (or `1000` without `ALU_MUL_EN`) -> `err=1`, `result=0`, `zero=1`, 1-cycle latency.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked, registered WIDTH-bit ALU with an optional shift-add multiplier.
// Define ALU_MUL_EN to compile in the multiplier; otherwise op 1000 is reserved.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             err,
    output logic [1:0]       dbg_state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Handshake: a bundle moves on any rising edge where valid & ready are both high;
    // in_ready depends only on state and out_ready, never on in_valid.
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, cout_q, ovf_q, err_q;
    logic             accept;
    logic             mul_last;

    logic [WIDTH:0]   sum_w, dif_w;
    logic             lt_w;
    logic [WIDTH-1:0] c_res;
    logic             c_cout, c_ovf, c_err, c_mul;

    assign in_ready    = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign out_valid   = (state_q == S_DONE);
    assign accept      = in_valid && in_ready;
    assign result      = result_q;
    assign zero        = zero_q;
    assign cout        = cout_q;
    assign overflow    = ovf_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

    always_comb begin
        sum_w  = {1'b0, a} + {1'b0, b};
        dif_w  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        lt_w   = dif_w[WIDTH-1] ^ ((a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]));
        c_res  = '0;
        c_cout = 1'b0;
        c_ovf  = 1'b0;
        c_err  = 1'b0;
        c_mul  = 1'b0;
        case (op)
            4'd0: begin
                c_res  = sum_w[WIDTH-1:0];
                c_cout = sum_w[WIDTH];
                c_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1: begin
                c_res  = dif_w[WIDTH-1:0];
                c_cout = dif_w[WIDTH];
                c_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2: c_res = ~a;
            4'd3: c_res = a & b;
            4'd4: c_res = a | b;
            4'd5: c_res = a ^ b;
            4'd6: c_res = {{(WIDTH-1){1'b0}}, lt_w};
            4'd7: c_res = {{(WIDTH-1){1'b0}}, (a == b)};
`ifdef ALU_MUL_EN
            4'd8: c_mul = 1'b1;
`else
            4'd8: c_err = 1'b1;
`endif
            default: c_err = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_nxt;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;

    assign acc_nxt  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mul_last = (cnt_q == CW'(WIDTH-1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (accept && c_mul) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            acc_q    <= '0;
            mplier_q <= b;
            cnt_q    <= '0;
        end else if (state_q == S_BUSY) begin
            acc_q    <= acc_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end
`else
    assign mul_last = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = c_mul ? S_BUSY : S_DONE;
                end else if ((state_q == S_DONE) && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (mul_last) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result flags only change when a new result is produced, so they hold under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else if (accept && !c_mul) begin
            result_q <= c_res;
            zero_q   <= (c_res == '0);
            cout_q   <= c_cout;
            ovf_q    <= c_ovf;
            err_q    <= c_err;
        end
`ifdef ALU_MUL_EN
        else if ((state_q == S_BUSY) && mul_last) begin
            result_q <= acc_nxt[WIDTH-1:0];
            zero_q   <= (acc_nxt[WIDTH-1:0] == '0);
            cout_q   <= |acc_nxt[2*WIDTH-1:WIDTH];
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed literal cases plus randomized traffic checked every
// cycle against a cycle-count/queue reference model (honours ALU_MUL_EN).
module tb_alu_seq;

    localparam int W = 4;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef logic [W+3:0] bundle_t;  // {err, overflow, cout, zero, result}

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero, cout, overflow, err;
    logic [1:0]   dbg_state;

    int      n_cmp = 0;
    int      n_fail = 0;
    bundle_t exp_q[$];
    int      m_busy = 0;
    bit      m_have = 1'b0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .cout(cout), .overflow(overflow), .err(err), .dbg_state_o(dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bundle_t ref_model(input logic [3:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
        int ux, uy, sx, sy, full, smax, smin, r;
        bit c, v, e;
        logic [W-1:0] rv;
        ux = int'(x); uy = int'(y);
        sx = $signed(x); sy = $signed(y);
        full = 1 << W; smax = (1 << (W-1)) - 1; smin = -(1 << (W-1));
        r = 0; c = 1'b0; v = 1'b0; e = 1'b0;
        case (o)
            4'd0: begin r = ux + uy; c = (r >= full); v = (sx+sy > smax) || (sx+sy < smin); end
            4'd1: begin r = ux - uy; c = (ux >= uy); v = (sx-sy > smax) || (sx-sy < smin); end
            4'd2: r = ~ux;
            4'd3: r = ux & uy;
            4'd4: r = ux | uy;
            4'd5: r = ux ^ uy;
            4'd6: r = (sx < sy) ? 1 : 0;
            4'd7: r = (ux == uy) ? 1 : 0;
            4'd8: begin
                if (MUL_EN) begin r = ux * uy; c = (r >= full); end
                else e = 1'b1;
            end
            default: e = 1'b1;
        endcase
        r = r & (full - 1);
        rv = r[W-1:0];
        return {e, v, c, (rv == '0), rv};
    endfunction

    // Reference model: tracks pending results and remaining multiply cycles.
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_busy = 0;
            m_have = 1'b0;
            exp_q.delete();
        end else begin
            bit ir, acc;
            ir  = (m_busy == 0) && (!m_have || out_ready);
            acc = in_valid && ir;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_have = 1'b1;
            end else begin
                if (m_have && out_ready) begin
                    void'(exp_q.pop_front());
                    m_have = 1'b0;
                end
                if (acc) begin
                    exp_q.push_back(ref_model(op, a, b));
                    if (MUL_EN && op == 4'd8) m_busy = W;
                    else m_have = 1'b1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("in_ready", in_ready, (m_busy == 0) && (!m_have || out_ready));
            check("out_valid", out_valid, m_have);
            if (m_have) begin
                if (exp_q.size() == 0) check("exp_q_empty", 1, 0);
                else check("bundle", {err, overflow, cout, zero, result}, exp_q[0]);
            end
        end
    end

    task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        bit got;
        got = 1'b0;
        in_valid = 1'b1; op = o; a = x; b = y;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("send_accept", got, 1);
    endtask

    task automatic expect_out(input string name, input int exp_lat, input bundle_t exp_b,
                              input bit chk_busy);
        int lat;
        bit seen;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 30) begin
            @(negedge clk);
            lat++;
            if (out_valid) seen = 1'b1;
            else begin
                if (chk_busy) check({name, "_busy_in_ready"}, in_ready, 0);
                @(posedge clk); #1;
            end
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_bundle"}, {err, overflow, cout, zero, result}, exp_b);
        if (seen) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset(input string name);
        check(name, {out_valid, in_ready, err, overflow, cout, zero, result},
              {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000});
    endtask

    initial begin
        #100000;
        check("watchdog", 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        bit last_acc;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_state");
        rst = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        send(4'd0, 4'd7, 4'd9);
        expect_out("add_7_9", 1, 8'b0_0_1_1_0000, 1'b0);
        send(4'd1, 4'd3, 4'd5);
        expect_out("sub_3_5", 1, 8'b0_0_0_0_1110, 1'b0);
        send(4'd6, 4'b1000, 4'b0111);
        expect_out("lt_m8_7", 1, 8'b0_0_0_0_0001, 1'b0);
        send(4'd7, 4'd5, 4'd5);
        expect_out("eq_5_5", 1, 8'b0_0_0_0_0001, 1'b0);

        out_ready = 1'b0;
        send(4'd5, 4'b1100, 4'b1010);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold", {out_valid, in_ready, result}, {1'b1, 1'b0, 4'b0110});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        in_valid = 1'b1; op = 4'd0; a = 4'd1; b = 4'd2;
        @(negedge clk);
        check("bp_same_edge_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        expect_out("bp_next_add", 1, 8'b0_0_0_0_0011, 1'b0);

        send(4'd8, 4'd7, 4'd6);
        if (MUL_EN) expect_out("mul_7_6", 5, 8'b0_0_1_0_1010, 1'b1);
        else expect_out("mul_reserved", 1, 8'b1_0_0_1_0000, 1'b0);

        send(4'd8, 4'd7, 4'd6);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_reset("reset_mid_op");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send(4'd0, 4'd1, 4'd1);
        expect_out("add_after_reset", 1, 8'b0_0_0_0_0010, 1'b0);

        send(4'd15, 4'd3, 4'd4);
        expect_out("reserved_1111", 1, 8'b1_0_0_1_0000, 1'b0);

        last_acc = 1'b1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15))
                                                 : 4'($urandom_range(0, 8));
                a = W'($urandom_range(0, (1 << W) - 1));
                b = W'($urandom_range(0, (1 << W) - 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            last_acc = in_valid && in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
